uart_tx: RTL and testbench

UART transmit path: accepts a parallel word and shifts it out on a single serial line as start bit, DATA_WIDTH data bits LSB first, optional parity bit, and stop bit, one bit per `clk` cycle. It is the TX counterpart of the UART RX path, whose deserializer reassembles LSB-first frames. It sits in the UART block, clocked by the TX baud clock, and is fed from the system-side data synchronizer or FIFO.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_if.sv | 30 +++
 rtl/uart_tx_serializer.sv | 39 +++
 rtl/uart_tx.sv | 121 ++++++++++++
 tb/tb_uart_tx.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity type codes and the
// default payload width used by the TX path and its sub-modules.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side handshake plus serial line of the UART transmitter.
// master: the data source (synchronizer/FIFO side); slave: uart_tx.
interface uart_tx_if #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  tx_out;
    logic                  busy;

    modport master (
        output p_data,
        output data_valid,
        output par_en,
        output par_typ,
        input  tx_out,
        input  busy
    );

    modport slave (
        input  p_data,
        input  data_valid,
        input  par_en,
        input  par_typ,
        output tx_out,
        output busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Shift register plus bit counter for the TX payload. ser_bit is the next
// payload bit (LSB first); ser_done rises once every payload bit has been
// shifted out, so the FSM can leave DATA on the following edge.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ser_bit,
    output logic                  ser_done
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;

    // Load a fresh word on acceptance, otherwise shift right one bit per enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (load) begin
            shift_reg <= data;
            bit_cnt   <= '0;
        end else if (shift_en) begin
            shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
        end
    end

    assign ser_bit  = shift_reg[0];
    assign ser_done = (bit_cnt == CNT_W'(DATA_WIDTH));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB first, optional parity,
// stop bit, one bit per clk. Optional parity is built only when the macro
// UART_TX_PARITY_EN is defined; otherwise par_en/par_typ are ignored.
//
// state  | meaning
// IDLE   | line high, waiting for data_valid
// START  | start bit (0) on the line
// DATA   | payload bits on the line, LSB first
// PARITY | parity bit on the line
// STOP   | stop bit (1); a new request here starts the next frame directly
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave bus
);
    state_t state;
    logic   tx_q;
    logic   busy_q;
    logic   accept;
    logic   load;
    logic   shift_en;
    logic   ser_bit;
    logic   ser_done;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic parity_q;
`else
    logic unused_par;
    assign unused_par = bus.par_en ^ bus.par_typ;
`endif

    // Accepting in STOP as well as IDLE gives back-to-back frames with no idle bit.
    assign accept   = ((state == IDLE) || (state == STOP)) && bus.data_valid;
    assign load     = accept;
    assign shift_en = (state == START) || ((state == DATA) && !ser_done);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .shift_en (shift_en),
        .data     (bus.p_data),
        .ser_bit  (ser_bit),
        .ser_done (ser_done)
    );

    // Frame sequencer with registered line and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q <= 1'b0;
            parity_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, STOP: begin
                    if (accept) begin
                        state  <= START;
                        tx_q   <= 1'b0;
                        busy_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        par_en_q <= bus.par_en;
                        parity_q <= (bus.par_typ == PAR_ODD) ? ~^bus.p_data : ^bus.p_data;
`endif
                    end else begin
                        state  <= IDLE;
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                START: begin
                    state <= DATA;
                    tx_q  <= ser_bit;
                end
                DATA: begin
                    if (ser_done) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state <= PARITY;
                            tx_q  <= parity_q;
                        end else begin
                            state <= STOP;
                            tx_q  <= 1'b1;
                        end
`else
                        state <= STOP;
                        tx_q  <= 1'b1;
`endif
                    end else begin
                        tx_q <= ser_bit;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    state <= STOP;
                    tx_q  <= 1'b1;
                end
`endif
                default: begin
                    state  <= IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_out = tx_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx. Expected serial lines are written out by hand,
// first transmitted bit leftmost. Parity expectations follow
// UART_TX_PARITY_EN so the bench matches whichever build it is compiled with.
module tb_uart_tx;
    import uart_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    uart_tx_if #(.DATA_WIDTH(8)) bus ();

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requests a frame, then checks every line bit and busy until the frame ends.
    // At sample mut_at the inputs are disturbed to show they were latched.
    task automatic send_and_check(input logic [7:0] data, input logic pe, input logic pt,
                                  input logic [31:0] exp_line, input int nbits,
                                  input int mut_at, input string name);
        bus.p_data     = data;
        bus.par_en     = pe;
        bus.par_typ    = pt;
        bus.data_valid = 1'b1;
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == mut_at) begin
                bus.p_data  = ~bus.p_data;
                bus.par_typ = ~bus.par_typ;
                bus.par_en  = ~bus.par_en;
            end
            vectors++;
            if (bus.tx_out !== exp_line[nbits-1-i] || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s bit %0d: tx_out=%b busy=%b, expected tx_out=%b busy=1",
                         name, i, bus.tx_out, bus.busy, exp_line[nbits-1-i]);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s end: tx_out=%b busy=%b, expected tx_out=1 busy=0",
                     name, bus.tx_out, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.p_data     = 8'h00;
        bus.data_valid = 1'b0;
        bus.par_en     = 1'b0;
        bus.par_typ    = 1'b0;
        #12;
        vectors++;
        if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_asserted: tx_out=%b busy=%b, expected 1/0", bus.tx_out, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL idle cycle %0d: tx_out=%b busy=%b, expected 1/0",
                         i, bus.tx_out, bus.busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_parity();
        logic [31:0] line;
        line = 32'b0101001011;
        send_and_check(8'hA5, 1'b0, PAR_EVEN, line, 10, -1, "a5_nopar");
        @(posedge clk); #1;
    endtask

    task automatic test_parity();
        logic [31:0] line_even;
        logic [31:0] line_odd;
`ifdef UART_TX_PARITY_EN
        line_even = 32'b01010010101;
        line_odd  = 32'b01010010111;
        send_and_check(8'hA5, 1'b1, PAR_EVEN, line_even, 11, -1, "a5_even");
        send_and_check(8'hA5, 1'b1, PAR_ODD,  line_odd,  11, -1, "a5_odd");
`else
        line_even = 32'b0101001011;
        line_odd  = 32'b0101001011;
        send_and_check(8'hA5, 1'b1, PAR_EVEN, line_even, 10, -1, "a5_even_noparbuild");
        send_and_check(8'hA5, 1'b1, PAR_ODD,  line_odd,  10, -1, "a5_odd_noparbuild");
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] line;
        line = 32'b0100000001_0000000011;
        bus.p_data     = 8'h01;
        bus.par_en     = 1'b0;
        bus.par_typ    = PAR_EVEN;
        bus.data_valid = 1'b1;
        @(posedge clk); #1;
        bus.p_data = 8'h80;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) bus.data_valid = 1'b0;
            vectors++;
            if (bus.tx_out !== line[19-i] || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b bit %0d: tx_out=%b busy=%b, expected tx_out=%b busy=1",
                         i, bus.tx_out, bus.busy, line[19-i]);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b end: tx_out=%b busy=%b, expected 1/0", bus.tx_out, bus.busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] line;
        line = 32'b0001111001;
        bus.p_data     = 8'hA5;
        bus.par_en     = 1'b0;
        bus.par_typ    = PAR_EVEN;
        bus.data_valid = 1'b1;
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (bus.tx_out !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset bit3: tx_out=%b busy=%b, expected 0/1", bus.tx_out, bus.busy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: tx_out=%b busy=%b, expected 1/0", bus.tx_out, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset idle %0d: tx_out=%b busy=%b, expected 1/0",
                         i, bus.tx_out, bus.busy);
            end
        end
        send_and_check(8'h3C, 1'b0, PAR_EVEN, line, 10, -1, "3c_after_reset");
        @(posedge clk); #1;
    endtask

    task automatic test_latching();
        logic [31:0] line;
`ifdef UART_TX_PARITY_EN
        line = 32'b00110100111;
        send_and_check(8'h96, 1'b1, PAR_ODD, line, 11, 2, "96_latched");
`else
        line = 32'b0011010011;
        send_and_check(8'h96, 1'b1, PAR_ODD, line, 10, 2, "96_latched");
`endif
        bus.p_data  = 8'h00;
        bus.par_en  = 1'b0;
        bus.par_typ = PAR_EVEN;
        @(posedge clk); #1;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_no_parity();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_latching();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
